// File: rtl/i2c_slave_datapath.sv
// rtl/i2c_slave_datapath.sv - I2C slave bit-level datapath (5-bit frames, MSB first)
// Optional general-call address support: define I2C_SLAVE_GENCALL_EN.
module i2c_slave_datapath #(
   parameter logic [3:0] SLAVE_ADDR = 4'hA,
   parameter logic [4:0] TX_RESET   = 5'h00
) (
   input  logic       clk1,
   input  logic       rst,
   input  logic       sda_in,
   input  logic [2:0] state,
   input  logic       rw,
   output logic [2:0] count,
   output logic [2:0] count_receive,
   output logic       ack,
   output logic       error_detected,
   output logic       master_read,
   output logic       sda_out,
   output logic       sda_oe,
   input  logic [4:0] tx_data,
   output logic [4:0] rx_data,
   output logic       rx_valid,
   output logic       gen_call
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ADDR = 3'd3;
   localparam logic [2:0] ST_ACK1 = 3'd2;
   localparam logic [2:0] ST_DATA = 3'd6;
   localparam logic [2:0] ST_ACK2 = 3'd7;

   logic [2:0] count_q, count_d;
   logic [2:0] count_receive_q, count_receive_d;
   logic       ack_q, ack_d;
   logic       error_q, error_d;
   logic       master_read_q, master_read_d;
   logic [4:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic [3:0] shift_q, shift_d;
   logic [4:0] tx_q, tx_d;
   logic       addr_last;

   // Address and write data share one 4-bit history; the 5th bit is taken live from sda_in.
   assign addr_last = (state == ST_ADDR) && (count_receive_q == 3'd4);

   always_comb begin
      count_d         = count_q;
      count_receive_d = count_receive_q;
      ack_d           = ack_q;
      error_d         = error_q;
      master_read_d   = master_read_q;
      rx_data_d       = rx_data_q;
      rx_valid_d      = 1'b0;
      shift_d         = shift_q;
      tx_d            = tx_q;
      case (state)
         ST_IDLE: begin
            count_d         = 3'd0;
            count_receive_d = 3'd0;
            ack_d           = 1'b0;
            error_d         = 1'b0;
            master_read_d   = 1'b0;
            shift_d         = 4'd0;
            tx_d            = TX_RESET;
         end
         ST_ADDR: begin
            shift_d         = {shift_q[2:0], sda_in};
            count_receive_d = count_receive_q + 3'd1;
            if (addr_last) begin
               master_read_d   = sda_in;
               count_receive_d = 3'd0;
`ifdef I2C_SLAVE_GENCALL_EN
               if (shift_q == 4'h0)
                  error_d = sda_in;
               else
                  error_d = (shift_q != SLAVE_ADDR);
`else
               error_d = (shift_q != SLAVE_ADDR);
`endif
            end
         end
         ST_ACK1: begin
            if (master_read_q && !error_q)
               tx_d = tx_data;
         end
         ST_DATA: begin
            if (master_read_q) begin
               tx_d    = {tx_q[3:0], 1'b0};
               count_d = (count_q == 3'd4) ? 3'd0 : count_q + 3'd1;
            end else begin
               shift_d         = {shift_q[2:0], sda_in};
               count_receive_d = count_receive_q + 3'd1;
               if (count_receive_q == 3'd4) begin
                  rx_data_d       = {shift_q, sda_in};
                  rx_valid_d      = 1'b1;
                  count_receive_d = 3'd0;
               end
            end
         end
         ST_ACK2: begin
            if (master_read_q)
               ack_d = ~sda_in;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk1) begin
      if (!rst) begin
         count_q         <= 3'd0;
         count_receive_q <= 3'd0;
         ack_q           <= 1'b0;
         error_q         <= 1'b0;
         master_read_q   <= 1'b0;
         rx_data_q       <= 5'd0;
         rx_valid_q      <= 1'b0;
         shift_q         <= 4'd0;
         tx_q            <= TX_RESET;
      end else begin
         count_q         <= count_d;
         count_receive_q <= count_receive_d;
         ack_q           <= ack_d;
         error_q         <= error_d;
         master_read_q   <= master_read_d;
         rx_data_q       <= rx_data_d;
         rx_valid_q      <= rx_valid_d;
         shift_q         <= shift_d;
         tx_q            <= tx_d;
      end
   end

`ifdef I2C_SLAVE_GENCALL_EN
   logic gen_call_q;
   always_ff @(posedge clk1) begin
      if (!rst || state == ST_IDLE)
         gen_call_q <= 1'b0;
      else if (addr_last)
         gen_call_q <= (shift_q == 4'h0) && !sda_in;
   end
   assign gen_call = gen_call_q;
`else
   assign gen_call = 1'b0;
`endif

   always_comb begin
      sda_out = 1'b1;
      if (!rw) begin
         case (state)
            ST_ACK1: sda_out = error_q;
            ST_DATA: sda_out = master_read_q ? tx_q[4] : 1'b1;
            ST_ACK2: sda_out = master_read_q;
            default: sda_out = 1'b1;
         endcase
      end
   end

   assign sda_oe         = ~rw;
   assign count          = count_q;
   assign count_receive  = count_receive_q;
   assign ack            = ack_q;
   assign error_detected = error_q;
   assign master_read    = master_read_q;
   assign rx_data        = rx_data_q;
   assign rx_valid       = rx_valid_q;

endmodule

// File: doc/i2c_slave_datapath.md
Name: i2c_slave_datapath

Overview:
- Bit-level datapath paired with the I2C slave FSM (control path). Consumes its `state` and `rw`; produces the `count`, `count_receive`, `ack`, `error_detected` and `master_read` it branches on.
- Deserializes the address frame and write data, serializes read data, and drives the slave SDA value.
- Bus frames are 5 bits, MSB first: address frame = 4-bit device address + R/W bit (1 = master reads); data frame = 5 bits.
- One SDA bit per `clk1` rising edge.

Parameters:
SLAVE_ADDR, 4'hA, device address matched in the address frame
TX_RESET, 5'h00, reset value of the transmit shift register

Ports:
clk1  in  1  bit clock; all registers update on rising edge
rst  in  1  synchronous active-low reset
sda_in  in  1  sampled SDA line
state  in  3  FSM state: idle=0, address=3, ack1=2, data=6, ack2=7, stop=5 (1, 4 unused)
rw  in  1  FSM direction: 1 = slave releases SDA, 0 = slave drives SDA
count  out  3  transmit bit counter (read data)
count_receive  out  3  receive bit counter (address / write data)
ack  out  1  master acknowledged slave read data
error_detected  out  1  address mismatch
master_read  out  1  latched R/W bit of the current transfer
sda_out  out  1  value slave places on SDA (1 = released)
sda_oe  out  1  slave drive enable = ~rw
tx_data  in  5  read data, sampled at the end of ack1
rx_data  out  5  last received write byte
rx_valid  out  1  one-cycle pulse when rx_data updates
gen_call  out  1  current transfer is a general call (see Optional Feature)

Behaviour:
- Reset (rst=0 at posedge clk1): count=0, count_receive=0, ack=0, error_detected=0, master_read=0, rx_data=0, rx_valid=0, gen_call=0, rx/addr shift=0, tx shift=TX_RESET.
- Reset wins over all activity mid-transfer; no rx_valid pulse is produced by an aborted frame.
- rx_valid defaults to 0 every cycle unless set below.
- idle:
  - Clear both counters and the shift registers.
  - Clear master_read, error_detected, ack and gen_call.
- address:
  - Each edge, shift sda_in into the addr shift register and increment count_receive (0,1,2,3,4).
  - On the edge with count_receive==4 (5th bit):
    - master_read <= sda_in
    - error_detected <= (shift[3:0] != SLAVE_ADDR)
    - count_receive <= 0
- ack1:
  - sda_out = error_detected ? 1 : 0, i.e. drive 0 = ACK.
  - On the exit edge, if master_read & !error_detected: tx shift <= tx_data.
- data, master_read=1:
  - sda_out = tx_shift[4].
  - Each edge, shift tx left (fill 0) and increment count.
  - On the count==4 edge, count <= 0.
- data, master_read=0:
  - Each edge, shift sda_in into the rx shift and increment count_receive.
  - On the count_receive==4 edge: rx_data <= {shift[3:0], sda_in}, rx_valid <= 1, count_receive <= 0.
- ack2, master_read=0: sda_out=0 (slave ACKs write).
- ack2, master_read=1:
  - SDA released (sda_out=1).
  - ack <= ~sda_in, registered so it is valid during stop.
- stop: hold all registers; sda_out=1.
- States 1 and 4: hold all registers; sda_out=1.
- sda_out is combinational from state, master_read, error_detected and the tx shift.
- Whenever rw=1, sda_out=1 regardless of state.
- Counters never exceed 4; they are cleared on the terminating edge, so there is no wrap-around.

Optional Feature:
- Macro I2C_SLAVE_GENCALL_EN.
- Defined: an address frame of 4'h0 with R/W=0 gives error_detected=0 and gen_call=1 until idle. Address 4'h0 with R/W=1 gives error_detected=1.
- Undefined: gen_call is tied 0, and 4'h0 matches only if SLAVE_ADDR==0.

Test Plan:
- Reset: hold rst=0 three cycles mid-address frame -> all outputs at reset values, sda_out=1, no rx_valid.
- Write: state seq idle,address x5 with SDA bits 1,0,1,0,0, ack1, data x5 with bits 1,0,1,1,0, ack2 -> master_read=0, error_detected=0, sda_out=0 in ack1 and ack2, rx_data=5'h16, rx_valid high exactly 1 cycle.
- Read: address bits 1,0,1,0,1, tx_data=5'h19, master ACKs with sda_in=0 in ack2 -> master_read=1, sda_out sequence 1,1,0,0,1 in data, count 0..4 then 0, ack=1 in stop.
- Read NACK: same as the read case with sda_in=1 in ack2 -> ack=0 in stop.
- Mismatch: address bits 0,1,1,1,0 -> error_detected=1, sda_out=1 in ack1, tx shift unchanged.
- Gencall (macro defined): address 0,0,0,0,0 -> error_detected=0, gen_call=1. With R/W=1 -> error_detected=1. Macro undefined -> error_detected=1, gen_call=0.
